hps_reset_pulse_seq: RTL
========================

// Module: hps_reset_pulse_seq
// PURPOSE
//  Parametrised successor to the per-request HPS reset pulse extenders. Takes NUM_CH
//  asynchronous reset-request levels (cold/warm/debug, etc.) and synchronises each one.
//  Edge-detects each channel with its own polarity and emits one stretched reset pulse per channel.
//  Pulses are serialised by priority so that at most one reset request reaches the HPS at a time.
//  Sits between the source/probe request bits and the HPS f2h_*_reset_req inputs.
// PARAMETERS
//  NUM_CH       3                  number of request channels; ch0 = highest priority
//  CNT_W        8                  width of each pulse-length field / counter
//  PULSE_LEN    {8'd32,8'd2,8'd6}  packed NUM_CH*CNT_W; field i = pulse length of ch i (0 treated as 1)
//  EDGE_RISE    3'b111             NUM_CH bits; 1 = trigger on rising edge, 0 = falling
//  SYNC_STAGES  2                  synchroniser depth, >=2
//  GAP_CYCLES   4                  minimum idle cycles between two consecutive pulses, >=1
// PORTS
//  clk        in   1              single clock
//  reset      in   1              synchronous, active-high
//  req        in   NUM_CH         async request levels
//  pulse      out  NUM_CH         active-high reset pulses; one-hot or zero
//  busy       out  1              high when not IDLE or when any pending bit is set
//  pending    out  NUM_CH         captured edges not yet served
// BEHAVIOUR
//  Reset values
//   - pulse=0, pending=0, busy=0.
//   - Sync chains and edge-history regs = 0; state=IDLE; counter=0; armed=0.
//  Arming
//   - armed sets after SYNC_STAGES+1 cycles with reset low.
//   - Edge detection is masked while armed=0, so a level already active at reset release gives no pulse.
//  Edge detect, per channel
//   - s = synchroniser output; h = s delayed one cycle.
//   - Rising channel: edge = s & ~h. Falling channel: edge = ~s & h.
//  Latency
//   - req changes between edges; pulse may go high after clock edge SYNC_STAGES+1.
//   - This holds only if the FSM is IDLE and no higher-priority channel is pending.
//  FSM states IDLE, PULSE, GAP
//   - IDLE: if (pending|edge) != 0, pick the lowest index i, load cnt = max(PULSE_LEN[i],1), set pulse[i], clear pending[i], go to PULSE.
//   - PULSE: decrement cnt each cycle. pulse[i] stays high exactly max(PULSE_LEN[i],1) cycles. At cnt==1, drop pulse, load gap counter GAP_CYCLES, go to GAP.
//   - GAP: pulse=0; decrement. After GAP_CYCLES cycles go to IDLE; IDLE may start the next pulse in that same cycle.
//  Pending rules
//   - An edge on channel j sets pending[j] unless j is the channel currently in PULSE.
//   - An edge on the channel currently in PULSE is dropped (ignore while busy).
//   - A second edge on an already-pending channel merges into that bit; no queue depth.
//  Simultaneous edges
//   - All edges are captured in the same cycle.
//   - In IDLE the lowest index is served at once; the others are set in pending.
//  No preemption: a higher-priority request waits for PULSE+GAP to finish.
//  Reset mid-pulse: pulse=0 after that edge; pending and counters cleared; armed restarts.
//  Counter arithmetic
//   - CNT_W-bit down counters; no wrap.
//   - Loading 0 is forced to 1.
//   - The gap counter is sized $clog2(GAP_CYCLES+1).
// CONFIGURATION
//  RSTSEQ_DROP_CNT_EN
//   - Defined: adds output port drop_cnt (out, NUM_CH*8): one counter per channel.
//   - Each counter counts dropped and merged edges, saturates at 255, and clears on reset.
//   - Undefined: no port and no counters; all other behaviour is identical.
// TESTING
//  1. Defaults; req=3'b001 step 10 cycles after armed -> pulse[0] high exactly 6 cycles, rising after edge 3; busy high for 6+4 cycles.
//  2. req 000->111 same cycle -> pulse[0] 6 cycles, 4 gap, pulse[1] 2 cycles, 4 gap, pulse[2] 32 cycles; pulse never multi-hot; pending 110->100->000.
//  3. During pulse[2], toggle req[2] low then high -> no extra pulse; with RSTSEQ_DROP_CNT_EN, drop_cnt[23:16]==1.
//  4. req[0] held high through reset release -> no pulse. Then drop req[0] and raise it again -> one 6-cycle pulse.
//  5. Assert reset at cycle 3 of pulse[2], with pending[0] set -> next cycle pulse=0, pending=0, busy=0; no pulse follows.
//  6. PULSE_LEN field 0, EDGE_RISE bit 0 on ch1; req[1] 1->0 -> exactly one 1-cycle pulse[1].

Source files
------------

// File: rtl/hps_reset_pulse_seq.sv
// Serialised, priority-ordered HPS reset pulse generator for NUM_CH request channels.
// Optional per-channel drop/merge counters: define RSTSEQ_DROP_CNT_EN.
module hps_reset_pulse_seq #(
    parameter int                       NUM_CH      = 3,
    parameter int                       CNT_W       = 8,
    parameter logic [NUM_CH*CNT_W-1:0]  PULSE_LEN   = {8'd32, 8'd2, 8'd6},
    parameter logic [NUM_CH-1:0]        EDGE_RISE   = 3'b111,
    parameter int                       SYNC_STAGES = 2,
    parameter int                       GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] pulse,
    output logic              busy,
    output logic [NUM_CH-1:0] pending
`ifdef RSTSEQ_DROP_CNT_EN
    ,
    output logic [NUM_CH*8-1:0] drop_cnt
`endif
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int AW = $clog2(SYNC_STAGES + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0] hist_q;
    logic [AW-1:0]     arm_cnt;
    logic              armed;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [GW-1:0]     gap_cnt;

    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] edge_v;
    logic [NUM_CH-1:0] req_vec;
    logic [NUM_CH-1:0] pick;
    logic [CNT_W-1:0]  pick_len;
    logic [CNT_W-1:0]  load_len;
    logic              found;
    logic              can_start;

    always_comb begin
        sync_s = sync_q[SYNC_STAGES-1];
        edge_v = ((EDGE_RISE & sync_s & ~hist_q) |
                  (~EDGE_RISE & ~sync_s & hist_q)) & {NUM_CH{armed}};
        req_vec  = pending | edge_v;
        pick     = '0;
        pick_len = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_vec[i]) begin
                found    = 1'b1;
                pick[i]  = 1'b1;
                pick_len = PULSE_LEN[i*CNT_W +: CNT_W];
            end
        end
        load_len = (pick_len == '0) ? CNT_W'(1) : pick_len;
        // The last gap cycle behaves as IDLE so the gap is exactly GAP_CYCLES long.
        can_start = (state == IDLE) ||
                    ((state == GAP) && (gap_cnt == GW'(1)));
        busy = (state != IDLE) || (|pending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            hist_q  <= '0;
            arm_cnt <= '0;
            armed   <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            pulse   <= '0;
            pending <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
            hist_q <= sync_s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
                if (arm_cnt == AW'(SYNC_STAGES))
                    armed <= 1'b1;
            end
            if (can_start && found) begin
                state   <= PULSE;
                cnt     <= load_len;
                gap_cnt <= '0;
                pulse   <= pick;
                pending <= req_vec & ~pick;
            end else begin
                // Edges on the channel being pulsed are dropped.
                pending <= pending | (edge_v & ~pulse);
                case (state)
                    PULSE: begin
                        if (cnt == CNT_W'(1)) begin
                            pulse   <= '0;
                            cnt     <= '0;
                            gap_cnt <= GW'(GAP_CYCLES);
                            state   <= GAP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GW'(1))
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RSTSEQ_DROP_CNT_EN
    logic [NUM_CH-1:0] dropped;

    assign dropped = edge_v & (pulse | pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (dropped[j] && (drop_cnt[j*8 +: 8] != 8'hff))
                    drop_cnt[j*8 +: 8] <= drop_cnt[j*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule
